// File: rtl/echo_dispatch_pkg.sv
// Shared types and helpers for the portal request dispatcher.
// Header word layout: [31:16] method number, [15:0] frame length in words including the header.
package echo_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE           = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN_METHOD = 2'd1;
  localparam logic [1:0] ERR_LEN_MISMATCH   = 2'd2;
  localparam logic [1:0] ERR_ZERO_LEN       = 2'd3;

  localparam int HDR_METHOD_MSB = 31;
  localparam int HDR_METHOD_LSB = 16;
  localparam int HDR_LEN_MSB    = 15;
  localparam int HDR_LEN_LSB    = 0;

  // Number of 32-bit words needed to carry 'bits' payload bits (ceiling division).
  function automatic logic [15:0] words_for_bits(input logic [15:0] bits);
    return 16'((32'(bits) + 32'd31) >> 5);
  endfunction

endpackage

// File: rtl/portal_hdr_decode.sv
// Combinational header check: compares the header length against the length implied
// by the messageSize lookup and reports the payload word count for the frame counter.
module portal_hdr_decode
  import echo_dispatch_pkg::*;
#(
  parameter int NUM_METHODS = 3,
  parameter int MAX_WORDS   = 16,
  parameter int CNT_W       = 5
) (
  input  logic [31:0]      hdr_i,
  input  logic [15:0]      size_bits_i,
  output logic             method_ok_o,
  output logic             len_ok_o,
  output logic             zero_len_o,
  output logic [CNT_W-1:0] payload_cnt_o
);

  logic [15:0] method_s;
  logic [15:0] len_s;
  logic [15:0] expected_s;

  assign method_s   = hdr_i[HDR_METHOD_MSB:HDR_METHOD_LSB];
  assign len_s      = hdr_i[HDR_LEN_MSB:HDR_LEN_LSB];
  assign expected_s = words_for_bits(size_bits_i) + 16'd1;

  assign method_ok_o = (method_s < 16'(NUM_METHODS));
  assign zero_len_o  = (len_s == 16'd0);
  // A frame longer than the counter can hold is never accepted as good.
  assign len_ok_o    = (len_s == expected_s) && (len_s <= 16'(MAX_WORDS));
  // Truncation to the counter width is intentional: oversize bad frames drain modulo 2**CNT_W.
  assign payload_cnt_o = CNT_W'(len_s - 16'd1);

endmodule

// File: rtl/echo_request_dispatch.sv
// Portal request path sequencer: validates framed header words and steers payload
// words straight through to the per-method request FIFO enq ports; bad frames are drained.
// Optional statistics counters are built when DISPATCH_STATS_EN is defined.
module echo_request_dispatch
  import echo_dispatch_pkg::*;
#(
  parameter int NUM_METHODS = 3,
  parameter int DATA_W      = 32,
  parameter int MAX_WORDS   = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [15:0]            size_method,
  input  logic [15:0]            size_bits,
  output logic [DATA_W-1:0]      req_enq_v,
  output logic [NUM_METHODS-1:0] req_enq_en,
  input  logic [NUM_METHODS-1:0] req_not_full,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic                   busy,
  output logic [31:0]            stat_msgs,
  output logic [15:0]            stat_errs
);

  localparam int CNT_W  = $clog2(MAX_WORDS + 1);
  localparam int MIDX_W = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
  localparam logic [NUM_METHODS-1:0] ENQ_ONE = NUM_METHODS'(1'b1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MIDX_W-1:0] method_q;
  logic              err_valid_q;
  logic [1:0]        err_code_q;

  logic              method_ok_s;
  logic              len_ok_s;
  logic              zero_len_s;
  logic [CNT_W-1:0]  payload_cnt_s;
  logic              hdr_only_s;
  logic [MIDX_W-1:0] hdr_idx_s;
  logic              in_ready_s;
  logic              fire_s;
  logic [NUM_METHODS-1:0] enq_en_s;
  logic [DATA_W-1:0] enq_v_s;

  portal_hdr_decode #(
    .NUM_METHODS (NUM_METHODS),
    .MAX_WORDS   (MAX_WORDS),
    .CNT_W       (CNT_W)
  ) u_hdr_decode (
    .hdr_i         (in_data[31:0]),
    .size_bits_i   (size_bits),
    .method_ok_o   (method_ok_s),
    .len_ok_o      (len_ok_s),
    .zero_len_o    (zero_len_s),
    .payload_cnt_o (payload_cnt_s)
  );

  assign size_method = in_data[HDR_METHOD_MSB:HDR_METHOD_LSB];
  assign hdr_idx_s   = MIDX_W'(in_data[HDR_METHOD_MSB:HDR_METHOD_LSB]);
  // Header-only frame: a good header whose payload is empty; the header itself is enqueued.
  assign hdr_only_s  = method_ok_s && len_ok_s && (payload_cnt_s == {CNT_W{1'b0}});

  // Handshake and zero-latency enq steering for the current state.
  always_comb begin
    in_ready_s = 1'b0;
    enq_en_s   = {NUM_METHODS{1'b0}};
    enq_v_s    = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (hdr_only_s) begin
          in_ready_s = req_not_full[hdr_idx_s];
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_PAYLOAD: in_ready_s = req_not_full[method_q];
      ST_DRAIN:   in_ready_s = 1'b1;
      default:    in_ready_s = 1'b0;
    endcase
    // Nothing is accepted or enqueued while reset is held.
    in_ready_s = in_ready_s & RST_N;
    fire_s     = in_valid & in_ready_s;
    if (fire_s && (state_q == ST_IDLE) && hdr_only_s) begin
      enq_en_s = ENQ_ONE << hdr_idx_s;
    end else if (fire_s && (state_q == ST_PAYLOAD)) begin
      enq_en_s = ENQ_ONE << method_q;
      enq_v_s  = in_data;
    end else begin
      enq_en_s = {NUM_METHODS{1'b0}};
    end
  end

  // Frame sequencer: header classification, payload/drain word counting, error pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      method_q    <= {MIDX_W{1'b0}};
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      case (state_q)
        ST_IDLE: begin
          if (fire_s) begin
            if (zero_len_s) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_ZERO_LEN;
            end else if (!method_ok_s || !len_ok_s) begin
              err_valid_q <= 1'b1;
              err_code_q  <= method_ok_s ? ERR_LEN_MISMATCH : ERR_UNKNOWN_METHOD;
              cnt_q       <= payload_cnt_s;
              if (payload_cnt_s != {CNT_W{1'b0}}) begin
                state_q <= ST_DRAIN;
              end else begin
                state_q <= ST_IDLE;
              end
            end else if (!hdr_only_s) begin
              method_q <= hdr_idx_s;
              cnt_q    <= payload_cnt_s;
              state_q  <= ST_PAYLOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_PAYLOAD, ST_DRAIN: begin
          if (fire_s) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_enq_en = enq_en_s;
  assign req_enq_v  = enq_v_s;
  assign in_ready   = in_ready_s;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef DISPATCH_STATS_EN
  logic        frame_done_s;
  logic [31:0] stat_msgs_q;
  logic [15:0] stat_errs_q;

  // A good frame completes on its last word: the header itself for header-only frames.
  assign frame_done_s = fire_s &&
                        (((state_q == ST_IDLE) && hdr_only_s) ||
                         ((state_q == ST_PAYLOAD) && (cnt_q == CNT_W'(1))));

  // Saturating good-frame and error counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_msgs_q <= 32'd0;
      stat_errs_q <= 16'd0;
    end else begin
      if (frame_done_s && (stat_msgs_q != 32'hFFFF_FFFF)) begin
        stat_msgs_q <= stat_msgs_q + 32'd1;
      end
      if (err_valid_q && (stat_errs_q != 16'hFFFF)) begin
        stat_errs_q <= stat_errs_q + 16'd1;
      end
    end
  end

  assign stat_msgs = stat_msgs_q;
  assign stat_errs = stat_errs_q;
`else
  assign stat_msgs = 32'd0;
  assign stat_errs = 16'd0;
`endif

endmodule

// File: tb/tb_echo_request_dispatch.sv
// Self-checking bench for echo_request_dispatch: directed scenarios followed by random frames,
// checked against a frame-level reference model (expected enq and error queues).
module tb_echo_request_dispatch;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [15:0] size_method;
  logic [15:0] size_bits;
  logic [31:0] req_enq_v;
  logic [2:0]  req_enq_en;
  logic [2:0]  req_not_full;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;
  logic [31:0] stat_msgs;
  logic [15:0] stat_errs;

  int checks   = 0;
  int failures = 0;
  int exp_msgs = 0;
  int exp_errs = 0;
  int cyc      = 0;

  logic [15:0] size_tbl [0:2];

  typedef struct {
    int          m;
    logic [31:0] d;
  } enq_t;

  enq_t exp_enq[$];
  int   exp_err[$];

  echo_request_dispatch dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .size_method  (size_method),
    .size_bits    (size_bits),
    .req_enq_v    (req_enq_v),
    .req_enq_en   (req_enq_en),
    .req_not_full (req_not_full),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .busy         (busy),
    .stat_msgs    (stat_msgs),
    .stat_errs    (stat_errs)
  );

  always #5 CLK = ~CLK;

  // messageSize lookup model: table for known methods, 32 bits for anything else.
  always_comb size_bits = (size_method < 16'd3) ? size_tbl[size_method[1:0]] : 16'd32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input int m);
    if (m < 3) return int'(size_tbl[m]);
    return 32;
  endfunction

  // Frame-level model: decide the outcome of a header and how many words follow it.
  task automatic model_hdr(input logic [31:0] h, output int n, output int gm);
    int len;
    int m;
    int e;
    len = int'(h[15:0]);
    m   = int'(h[31:16]);
    n   = 0;
    gm  = -1;
    if (len == 0) begin
      exp_err.push_back(3); exp_errs++;
    end else begin
      e = (size_of(m) + 31) / 32 + 1;
      if (m >= 3) begin
        exp_err.push_back(1); exp_errs++;
        n = (len - 1) % 32;
      end else if (len != e || len > 16) begin
        exp_err.push_back(2); exp_errs++;
        n = (len - 1) % 32;
      end else begin
        n  = len - 1;
        gm = m;
        if (len == 1) begin
          exp_enq.push_back('{m, 32'd0});
          exp_msgs++;
        end
      end
    end
  endtask

  // Offer one word until accepted; returns the enq outputs seen in the accepting cycle.
  task automatic send_word(input logic [31:0] d, input bit rnd,
                           output logic [2:0] en_o, output logic [31:0] v_o);
    bit done;
    int budget;
    done   = 1'b0;
    budget = 0;
    en_o   = 3'b000;
    v_o    = 32'd0;
    while (!done) begin
      @(negedge CLK);
      in_data  = d;
      in_valid = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      if (rnd) begin
        for (int i = 0; i < 3; i++) req_not_full[i] = ($urandom_range(3, 0) != 0);
      end
      cyc++;
      #1;
      if (in_valid && in_ready) begin
        done = 1'b1;
        en_o = req_enq_en;
        v_o  = req_enq_v;
        @(posedge CLK);
      end else begin
        budget++;
        if (budget > 200) begin
          checks++;
          failures++;
          $error("FAIL accept_timeout observed=no_accept expected=accept word=0x%0h", d);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] h, input bit rnd);
    int n;
    int gm;
    logic [2:0]  en;
    logic [31:0] v;
    logic [31:0] d;
    model_hdr(h, n, gm);
    send_word(h, rnd, en, v);
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (gm >= 0) begin
        exp_enq.push_back('{gm, d});
        if (i == n - 1) exp_msgs++;
      end
      send_word(d, rnd, en, v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef DISPATCH_STATS_EN
    chk({tag, "_stat_msgs"}, 64'(stat_msgs), 64'(exp_msgs));
    chk({tag, "_stat_errs"}, 64'(stat_errs), 64'(exp_errs));
`else
    chk({tag, "_stat_msgs_tied"}, 64'(stat_msgs), 64'd0);
    chk({tag, "_stat_errs_tied"}, 64'(stat_errs), 64'd0);
`endif
  endtask

  task automatic do_reset(input logic [31:0] d);
    @(negedge CLK);
    RST_N    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_enq_en", 64'(req_enq_en), 64'd0);
    exp_enq.delete();
    exp_err.delete();
    exp_msgs = 0;
    exp_errs = 0;
    check_stats("rst");
    @(negedge CLK);
    RST_N    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every enq strobe and error pulse must match the model's next expectation.
  always @(negedge CLK) begin
    enq_t e;
    int   c;
    #4;
    if (req_enq_en !== 3'b000) begin
      if (exp_enq.size() == 0) begin
        chk("enq_unexpected", 64'(req_enq_en), 64'd0);
      end else begin
        e = exp_enq.pop_front();
        chk("enq_strobe", 64'(req_enq_en), 64'(3'b001 << e.m));
        chk("enq_data", 64'(req_enq_v), 64'(e.d));
      end
    end
    if (err_valid !== 1'b0) begin
      if (exp_err.size() == 0) begin
        chk("err_unexpected", 64'(err_valid), 64'd0);
      end else begin
        c = exp_err.pop_front();
        chk("err_code", 64'(err_code), 64'(c));
      end
    end
  end

  initial begin
    int          n;
    int          gm;
    int          m;
    int          e;
    int          r;
    int          len;
    logic [2:0]  en;
    logic [31:0] v;
    int          sizes [8] = '{0, 8, 32, 33, 64, 100, 255, 480};

    size_tbl[0]  = 16'd32;
    size_tbl[1]  = 16'd32;
    size_tbl[2]  = 16'd8;
    RST_N        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 32'd0;
    req_not_full = 3'b111;

    // Reset state, plus the lookup method follows the header field.
    repeat (2) @(negedge CLK);
    in_valid = 1'b1;
    in_data  = 32'h0002_0002;
    #1;
    chk("rst0_in_ready", 64'(in_ready), 64'd0);
    chk("rst0_busy", 64'(busy), 64'd0);
    chk("rst0_err_valid", 64'(err_valid), 64'd0);
    chk("rst0_enq_en", 64'(req_enq_en), 64'd0);
    chk("size_method", 64'(size_method), 64'h0002);
    check_stats("rst0");
    @(negedge CLK);
    RST_N    = 1'b1;
    in_valid = 1'b0;

    // Method 0 single-word payload passes through the same cycle.
    model_hdr(32'h0000_0002, n, gm);
    send_word(32'h0000_0002, 1'b0, en, v);
    #1;
    chk("t1_busy", 64'(busy), 64'd1);
    exp_enq.push_back('{0, 32'hDEAD_BEEF});
    exp_msgs++;
    send_word(32'hDEAD_BEEF, 1'b0, en, v);
    chk("t1_enq_en", 64'(en), 64'h1);
    chk("t1_enq_v", 64'(v), 64'hDEAD_BEEF);
    idle(3);
    chk("t1_busy_after", 64'(busy), 64'd0);
    check_stats("t1");

    // Backpressure on FIFO 2 holds the payload word for five cycles.
    model_hdr(32'h0002_0002, n, gm);
    send_word(32'h0002_0002, 1'b0, en, v);
    exp_enq.push_back('{2, 32'h0000_00A5});
    exp_msgs++;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid     = 1'b1;
      in_data      = 32'h0000_00A5;
      req_not_full = 3'b011;
      #1;
      chk("t2_stall_ready", 64'(in_ready), 64'd0);
      chk("t2_stall_enq", 64'(req_enq_en), 64'd0);
    end
    @(negedge CLK);
    req_not_full = 3'b111;
    #1;
    chk("t2_ready", 64'(in_ready), 64'd1);
    chk("t2_enq_en", 64'(req_enq_en), 64'h4);
    @(posedge CLK);
    idle(2);

    // Unknown method: error pulse the cycle after the header, then two words drained.
    model_hdr(32'h0005_0003, n, gm);
    send_word(32'h0005_0003, 1'b0, en, v);
    #1;
    chk("t3_err_valid", 64'(err_valid), 64'd1);
    chk("t3_err_code", 64'(err_code), 64'd1);
    for (int i = 0; i < 2; i++) begin
      send_word(32'h1111_0000 + 32'(i), 1'b0, en, v);
      chk("t3_drain_enq", 64'(en), 64'd0);
    end
    idle(3);
    chk("t3_busy_after", 64'(busy), 64'd0);
    check_stats("t3");

    // Length mismatch drains three words, then a good method-1 frame dispatches.
    send_frame(32'h0001_0004, 1'b0);
    send_frame(32'h0001_0002, 1'b0);
    idle(2);

    // Zero length: error 3, no state change.
    model_hdr(32'h0000_0000, n, gm);
    send_word(32'h0000_0000, 1'b0, en, v);
    #1;
    chk("t5_err_code", 64'(err_code), 64'd3);
    chk("t5_busy", 64'(busy), 64'd0);
    idle(2);

    // Back-to-back good frames for methods 0, 1, 2: six words in six cycles.
    cyc = 0;
    send_frame(32'h0000_0002, 1'b0);
    send_frame(32'h0001_0002, 1'b0);
    send_frame(32'h0002_0002, 1'b0);
    chk("t6_cycles", 64'(cyc), 64'd6);
    idle(2);

    // Header-only frame (size 0 bits) is itself enqueued with zero data.
    size_tbl[1] = 16'd0;
    model_hdr(32'h0001_0001, n, gm);
    @(negedge CLK);
    in_valid     = 1'b1;
    in_data      = 32'h0001_0001;
    req_not_full = 3'b101;
    #1;
    chk("t8_ready_full", 64'(in_ready), 64'd0);
    @(negedge CLK);
    req_not_full = 3'b111;
    #1;
    chk("t8_ready", 64'(in_ready), 64'd1);
    chk("t8_enq_en", 64'(req_enq_en), 64'h2);
    chk("t8_enq_v", 64'(req_enq_v), 64'd0);
    @(posedge CLK);
    idle(3);
    chk("t8_busy", 64'(busy), 64'd0);
    check_stats("t8");
    size_tbl[1] = 16'd32;

    // Reset between header and payload abandons the frame.
    send_word(32'h0001_0002, 1'b0, en, v);
    #1;
    chk("t9_busy_mid", 64'(busy), 64'd1);
    do_reset(32'hCAFE_F00D);
    #1;
    chk("t9_busy_after", 64'(busy), 64'd0);
    send_frame(32'h0000_0002, 1'b0);
    idle(3);
    check_stats("t9");

    // Random frames, random gaps, random FIFO backpressure, changing lookup table.
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(4, 0) == 0) size_tbl[$urandom_range(2, 0)] = 16'(sizes[$urandom_range(7, 0)]);
      m   = ($urandom_range(9, 0) < 8) ? int'($urandom_range(2, 0)) : int'($urandom_range(6, 3));
      e   = (size_of(m) + 31) / 32 + 1;
      r   = int'($urandom_range(9, 0));
      len = (r < 7) ? e : ((r == 7) ? 0 : int'($urandom_range(40, 1)));
      send_frame({16'(m), 16'(len)}, 1'b1);
    end
    req_not_full = 3'b111;
    idle(4);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_enq_pending", 64'(exp_enq.size()), 64'd0);
    chk("end_err_pending", 64'(exp_err.size()), 64'd0);
    check_stats("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
